// File: rtl/input_manager.sv
// Button front end for a falling-block game: synchronizes and debounces six buttons,
// then turns them into one-clk action pulses with DAS/ARR auto-repeat on left, right and down.
module input_manager #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned DAS_TICKS       = 10,
  parameter int unsigned ARR_TICKS       = 3,
  parameter int unsigned DOWN_ARR_TICKS  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_game,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_down,
  input  logic btn_rotate,
  input  logic btn_drop,
  input  logic btn_hold,
  output logic key_left,
  output logic key_right,
  output logic key_down,
  output logic key_rotate,
  output logic key_drop,
  output logic key_hold,
  output logic key_drop_held
);

  localparam int NUM_BTN = 6;
  localparam int DB_W    = 20;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DAS, ST_REPEAT} rep_state_e;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] deb_lvl;

  // Bit order shared by all per-button vectors: left, right, down, rotate, drop, hold.
  assign btn_raw = {btn_hold, btn_drop, btn_rotate, btn_down, btn_right, btn_left};

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic            deb_q, deb_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    always_comb begin
      sync1_d = btn_raw[gi];
      sync2_d = sync1_q;
      deb_d   = deb_q;
      cnt_d   = '0;
      if (sync2_q != deb_q) begin
        if (cnt_q == DB_LAST) begin
          deb_d = sync2_q;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        deb_q   <= 1'b0;
        cnt_q   <= '0;
      end else begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
        deb_q   <= deb_d;
        cnt_q   <= cnt_d;
      end
    end

    assign deb_lvl[gi] = deb_q;
  end

  // Rotate, drop and hold fire once per debounced rising edge and never repeat.
  logic [2:0] prev_q, prev_d;
  logic [2:0] shot_q, shot_d;
  logic       held_q, held_d;

  always_comb begin
    prev_d = deb_lvl[5:3];
    shot_d = deb_lvl[5:3] & ~prev_q;
    held_d = deb_lvl[4];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q <= '0;
      shot_q <= '0;
      held_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      shot_q <= shot_d;
      held_q <= held_d;
    end
  end

  logic [2:0] rep_pulse;
  logic       lr_both;

  assign lr_both = deb_lvl[0] & deb_lvl[1];

  for (genvar gi = 0; gi < 3; gi++) begin : g_rep
    localparam int unsigned ARR_SEL  = (gi == 2) ? DOWN_ARR_TICKS : ARR_TICKS;
    localparam logic [7:0]  DAS_LAST = 8'(DAS_TICKS - 1);
    localparam logic [7:0]  ARR_LAST = 8'(ARR_SEL - 1);

    rep_state_e state_q;
    logic [7:0] cnt_q;
    logic       pulse_q;
    logic       lr_pause;
    logic [7:0] last;

    // Opposing horizontal directions freeze each other's repeat timing; down never pauses.
    assign lr_pause = (gi != 2) && lr_both;
    assign last     = (state_q == ST_DAS) ? DAS_LAST : ARR_LAST;

    always_ff @(posedge clk) begin
      if (!rst) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        case (state_q)
          ST_IDLE: begin
            if (deb_lvl[gi]) begin
              state_q <= ST_DAS;
              cnt_q   <= '0;
              pulse_q <= 1'b1;
            end
          end
          default: begin
            if (!deb_lvl[gi]) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
            end else if (tick_game && !lr_pause) begin
              if (cnt_q == last) begin
                state_q <= ST_REPEAT;
                cnt_q   <= '0;
                pulse_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 8'd1;
              end
            end
          end
        endcase
      end
    end

    assign rep_pulse[gi] = pulse_q;
  end

  assign key_left      = rep_pulse[0];
  assign key_right     = rep_pulse[1];
  assign key_down      = rep_pulse[2];
  assign key_rotate    = shot_q[0];
  assign key_drop      = shot_q[1];
  assign key_hold      = shot_q[2];
  assign key_drop_held = held_q;

endmodule

// File: tb/tb_input_manager.sv
// Directed bench for input_manager: a window/tick-count model checked every cycle,
// plus literal expectations for latencies, pulse counts and repeat tick positions.
module tb_input_manager;

  localparam int DB   = 4;
  localparam int DAS  = 3;
  localparam int ARR  = 2;
  localparam int DARR = 1;
  localparam int HL   = DB + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tick_game = 1'b0;
  logic btn_left = 1'b0, btn_right = 1'b0, btn_down = 1'b0;
  logic btn_rotate = 1'b0, btn_drop = 1'b0, btn_hold = 1'b0;
  logic key_left, key_right, key_down, key_rotate, key_drop, key_hold, key_drop_held;

  input_manager #(
    .DEBOUNCE_CYCLES(DB),
    .DAS_TICKS(DAS),
    .ARR_TICKS(ARR),
    .DOWN_ARR_TICKS(DARR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .tick_game(tick_game),
    .btn_left(btn_left),
    .btn_right(btn_right),
    .btn_down(btn_down),
    .btn_rotate(btn_rotate),
    .btn_drop(btn_drop),
    .btn_hold(btn_hold),
    .key_left(key_left),
    .key_right(key_right),
    .key_down(key_down),
    .key_rotate(key_rotate),
    .key_drop(key_drop),
    .key_hold(key_hold),
    .key_drop_held(key_drop_held)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int edge_cnt = 0;

  // Model: debounced level flips once the synchronized input has shown the other value
  // for DB consecutive samples; repeats fire at effective tick counts DAS, DAS+ARR, ...
  logic [HL-1:0] hist [6];
  logic [5:0]    md1, md2;
  int            eff [3];
  logic [6:0]    exp_out = '0;
  bit            model_valid = 1'b0;

  always @(posedge clk) begin
    logic [5:0] raw;
    logic [5:0] nd;
    logic [6:0] e;
    bit         pause;
    int         arr;
    edge_cnt++;
    if (!rst) begin
      for (int k = 0; k < 6; k++) hist[k] = '0;
      for (int i = 0; i < 3; i++) eff[i] = 0;
      md1 = '0;
      md2 = '0;
      exp_out = '0;
      model_valid = 1'b1;
    end else begin
      raw   = {btn_hold, btn_drop, btn_rotate, btn_down, btn_right, btn_left};
      e     = '0;
      pause = md1[0] & md1[1];
      for (int i = 0; i < 3; i++) begin
        arr = (i == 2) ? DARR : ARR;
        if (!md1[i]) begin
          eff[i] = 0;
        end else if (!md2[i]) begin
          e[i]   = 1'b1;
          eff[i] = 0;
        end else if (tick_game && !(pause && i < 2)) begin
          eff[i]++;
          if (eff[i] == DAS || (eff[i] > DAS && (eff[i] - DAS) % arr == 0)) e[i] = 1'b1;
        end
      end
      for (int k = 3; k < 6; k++) e[k] = md1[k] & ~md2[k];
      e[6] = md1[4];
      for (int k = 0; k < 6; k++) begin
        hist[k] = {hist[k][HL-2:0], raw[k]};
        if (hist[k][HL-1:2] == '1)      nd[k] = 1'b1;
        else if (hist[k][HL-1:2] == '0) nd[k] = 1'b0;
        else                            nd[k] = md1[k];
      end
      md2 = md1;
      md1 = nd;
      exp_out = e;
    end
  end

  logic [5:0] prev_keys = '0;

  always @(negedge clk) begin
    logic [6:0] dut_out;
    if (model_valid) begin
      dut_out = {key_drop_held, key_hold, key_drop, key_rotate, key_down, key_right, key_left};
      n_checks++;
      if (dut_out !== exp_out) begin
        n_errors++;
        $display("FAIL model_cmp edge=%0d got=%b expected=%b", edge_cnt, dut_out, exp_out);
      end
      n_checks++;
      if ((dut_out[5:0] & prev_keys) != 6'd0) begin
        n_errors++;
        $display("FAIL back_to_back edge=%0d got=%b prev=%b expected no overlap", edge_cnt, dut_out[5:0], prev_keys);
      end
      prev_keys = dut_out[5:0];
    end
  end

  int         pcount [6];
  int         first [6];
  int         mark = 0;
  logic [5:0] last_keys = '0;
  logic [5:0] tick_keys = '0;
  bit         drop_held_bad = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d", name, act, expv);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    last_keys = {key_hold, key_drop, key_rotate, key_down, key_right, key_left};
    for (int k = 0; k < 6; k++) begin
      if (last_keys[k]) begin
        pcount[k]++;
        if (first[k] < 0) first[k] = edge_cnt - mark;
      end
    end
    if (key_drop && !key_drop_held) drop_held_bad = 1'b1;
  endtask

  task automatic clear();
    for (int k = 0; k < 6; k++) begin
      pcount[k] = 0;
      first[k]  = -1;
    end
    mark = edge_cnt;
  endtask

  task automatic tick();
    tick_game = 1'b1;
    cyc();
    tick_game = 1'b0;
    tick_keys = last_keys;
    repeat (3) cyc();
  endtask

  task automatic wait_pulse(input int k);
    for (int i = 0; i < 20 && pcount[k] == 0; i++) cyc();
  endtask

  initial begin
    logic [7:0] mask;
    int         mk;
    clear();
    repeat (3) cyc();
    check("reset_outputs", int'({key_drop_held, last_keys}), 0);
    rst = 1'b1;
    repeat (2) cyc();

    // Short glitch, then a real rotate press.
    clear();
    btn_rotate = 1'b1;
    repeat (2) cyc();
    btn_rotate = 1'b0;
    repeat (12) cyc();
    check("glitch_rotate_pulses", pcount[3], 0);
    clear();
    btn_rotate = 1'b1;
    repeat (20) cyc();
    btn_rotate = 1'b0;
    repeat (12) cyc();
    check("rotate_pulses", pcount[3], 1);
    check("rotate_latency", first[3], 7);

    // Left DAS/ARR.
    clear();
    btn_left = 1'b1;
    wait_pulse(0);
    check("left_press_latency", first[0], 7);
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      mask[i] = tick_keys[0];
    end
    check("left_tick_mask", int'(mask), 8'b0101_0100);
    check("left_pulses", pcount[0], 4);
    btn_left = 1'b0;
    repeat (10) cyc();
    repeat (3) tick();
    check("left_after_release", pcount[0], 4);

    // Down repeats every tick after DAS.
    clear();
    btn_down = 1'b1;
    wait_pulse(2);
    mask = '0;
    for (int i = 0; i < 5; i++) begin
      tick();
      mask[i] = tick_keys[2];
    end
    check("down_tick_mask", int'(mask), 8'b0001_1100);
    check("down_pulses", pcount[2], 4);
    btn_down = 1'b0;
    repeat (10) cyc();

    // Left in REPEAT, right pressed: both freeze, left resumes after right releases.
    clear();
    btn_left = 1'b1;
    wait_pulse(0);
    repeat (4) tick();
    btn_right = 1'b1;
    wait_pulse(1);
    repeat (6) tick();
    check("pause_left_pulses", pcount[0], 2);
    check("pause_right_pulses", pcount[1], 1);
    btn_right = 1'b0;
    repeat (10) cyc();
    mask = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      mask[i] = tick_keys[0];
    end
    check("resume_left_mask", int'(mask), 8'b0000_0101);
    check("resume_left_total", pcount[0], 4);
    check("resume_right_total", pcount[1], 1);
    btn_left = 1'b0;
    repeat (10) cyc();

    // Drop: single pulse, held level tracks debounced button.
    clear();
    drop_held_bad = 1'b0;
    btn_drop = 1'b1;
    repeat (50) cyc();
    check("drop_pulses", pcount[4], 1);
    check("drop_held_level", int'(key_drop_held), 1);
    check("drop_held_at_pulse_bad", int'(drop_held_bad), 0);
    mk = edge_cnt;
    btn_drop = 1'b0;
    for (int i = 0; i < 20 && key_drop_held; i++) cyc();
    check("drop_held_fall_latency", edge_cnt - mk, 7);
    repeat (5) cyc();
    check("drop_pulses_after_release", pcount[4], 1);

    // Reset during left REPEAT with the button still held.
    clear();
    btn_left = 1'b1;
    wait_pulse(0);
    repeat (4) tick();
    rst = 1'b0;
    cyc();
    check("midop_reset_outputs", int'({key_drop_held, last_keys}), 0);
    rst = 1'b1;
    clear();
    wait_pulse(0);
    check("post_reset_latency", first[0], 7);
    mask = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      mask[i] = tick_keys[0];
    end
    check("post_reset_das_mask", int'(mask), 8'b0000_0100);
    check("post_reset_pulses", pcount[0], 2);
    btn_left = 1'b0;
    repeat (10) cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at edge=%0d expected completion", edge_cnt);
    $fatal(1, "watchdog");
  end

endmodule
